// File: rtl/uabc_accum_alu.sv
// Purpose : registered add/sub/accumulate ALU with optional saturation and a sticky overflow flag.
// Latency : 1 cycle from accept to out_valid; 1 op/cycle while out_ready is high.
// Backpr. : one-deep output register; in_ready = !out_valid || out_ready, result held while stalled.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   operand handshake carrying a, b, mode, clear
//   a, b                unsigned operands (WIDTH bits)
//   mode                00 ADD, 01 SUB, 10 ACC, 11 DACC
//   clear               zeroes acc, ovf and op_count ahead of the accepted op
//   out_valid/out_ready result handshake
//   result              registered result (ACC_WIDTH bits)
//   ovf                 sticky overflow/underflow flag
//   op_count            accepted-operation counter, wraps
module uabc_accum_alu #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 10,
  parameter int SATURATE  = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           mode,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 ovf,
  output logic [CNT_WIDTH-1:0] op_count
);

  // One guard bit above the accumulator width. With ACC_WIDTH >= WIDTH+1 the
  // largest ACC sum (acc + a + b) and the most negative difference both fit,
  // so the guard bit alone tells whether the result left [0, 2^ACC_WIDTH-1].
  localparam int EXT_W = ACC_WIDTH + 1;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_DACC = 2'b11
  } mode_e;

  generate
    if (ACC_WIDTH < WIDTH + 1) begin : g_width_check
      $error("uabc_accum_alu: ACC_WIDTH must be at least WIDTH+1");
    end
  endgenerate

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_eff;
  logic [EXT_W-1:0]     a_x;
  logic [EXT_W-1:0]     b_x;
  logic [EXT_W-1:0]     acc_x;
  logic [EXT_W-1:0]     raw;
  logic                 range_err;
  logic [ACC_WIDTH-1:0] sat_val;
  logic [ACC_WIDTH-1:0] op_res;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 ovf_base;
  logic [CNT_WIDTH-1:0] cnt_base;
  logic                 accept;
  logic                 fire;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign fire     = out_valid && out_ready;

  // clear takes effect before the op that carries it
  assign acc_eff  = clear ? '0 : acc;
  assign ovf_base = clear ? 1'b0 : ovf;
  assign cnt_base = clear ? '0 : op_count;

  assign a_x   = EXT_W'(a);
  assign b_x   = EXT_W'(b);
  assign acc_x = EXT_W'(acc_eff);

  always_comb begin
    raw = '0;
    case (mode_e'(mode))
      MODE_ADD:  raw = a_x + b_x;
      MODE_SUB:  raw = a_x - b_x;
      MODE_ACC:  raw = acc_x + a_x + b_x;
      MODE_DACC: raw = acc_x - a_x;
      default:   raw = '0;
    endcase
  end

  // Guard bit set means carry-out for the adding modes, borrow for the
  // subtracting ones (mode[0] = 1). ADD can never set it.
  assign range_err = raw[EXT_W-1];
  assign sat_val   = mode[0] ? '0 : '1;
  assign op_res    = (range_err && (SATURATE != 0)) ? sat_val : raw[ACC_WIDTH-1:0];

  // Only ACC/DACC write the accumulator; a clear on ADD/SUB still zeroes it.
  assign acc_next  = mode[1] ? op_res : acc_eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      op_count  <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        result    <= op_res;
        acc       <= acc_next;
        ovf       <= ovf_base | range_err;
        op_count  <= cnt_base + CNT_WIDTH'(1);
      end else if (fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uabc_accum_alu.sv
module tb_uabc_accum_alu;

  localparam int WIDTH     = 8;
  localparam int ACC_WIDTH = 10;
  localparam int SAT       = 1;
  localparam int CNT_WIDTH = 16;
  localparam int ACC_MAX   = (1 << ACC_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [1:0]           mode;
  logic                 clear;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] result;
  logic                 ovf;
  logic [CNT_WIDTH-1:0] op_count;

  uabc_accum_alu #(
    .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .SATURATE(SAT), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int total    = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  // Reference model: transaction-level view of the block.
  int m_acc, m_ovf, m_cnt, m_res;
  bit m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_ovf = 0; m_cnt = 0; m_res = 0; m_valid = 0;
  endtask

  task automatic model_op(input int md, input int ia, input int ib, input bit clr);
    int base, r, ov;
    base = clr ? 0 : m_acc;
    if (clr) begin m_acc = 0; m_ovf = 0; m_cnt = 0; end
    case (md)
      0: r = ia + ib;
      1: r = ia - ib;
      2: r = base + ia + ib;
      default: r = base - ia;
    endcase
    ov = 0;
    if (r < 0) begin
      ov = 1;
      r = SAT ? 0 : r + ACC_MAX + 1;
    end else if (r > ACC_MAX) begin
      ov = 1;
      r = SAT ? ACC_MAX : r - (ACC_MAX + 1);
    end
    if (md >= 2) m_acc = r;
    m_ovf = m_ovf | ov;
    m_cnt = (m_cnt + 1) % (1 << CNT_WIDTH);
    m_res = r;
  endtask

  // One clock: drive inputs, check in_ready, advance, check outputs.
  task automatic step(input bit iv, input int md, input int ia, input int ib,
                      input bit clr, input bit ordy);
    bit exp_rdy;
    in_valid  = iv;
    mode      = 2'(md);
    a         = 8'(ia);
    b         = 8'(ib);
    clear     = clr;
    out_ready = ordy;
    #1;
    exp_rdy = !m_valid || ordy;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    #1;
    if (iv && exp_rdy) begin
      model_op(md, ia, ib, clr);
      m_valid = 1;
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) chk("result", 32'(result), m_res);
    chk("ovf", {31'd0, ovf}, 32'(m_ovf));
    chk("op_count", 32'(op_count), m_cnt);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; a = 0; b = 0; mode = 0; clear = 0; out_ready = 1;

    // 1. reset state
    do_reset(2);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    chk("rst_op_count", 32'(op_count), 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);

    // 2. ADD / SUB
    step(1, 0, 200, 100, 0, 1); chk("add_300", 32'(result), 300);
    step(1, 1, 9, 5, 0, 1);     chk("sub_4", 32'(result), 4);

    // 3. accumulate up to saturation
    step(1, 2, 255, 255, 1, 1); chk("acc_510", 32'(result), 510);
    step(1, 2, 255, 255, 0, 1); chk("acc_1020", 32'(result), 1020);
    step(1, 2, 10, 0, 0, 1);    chk("acc_sat", 32'(result), SAT ? 1023 : 6);
    chk("acc_sat_ovf", {31'd0, ovf}, 1);
    step(1, 0, 1, 1, 0, 1);     chk("add_2", 32'(result), 2);
    chk("ovf_sticky", {31'd0, ovf}, 1);

    // clear without accept has no effect
    step(0, 2, 0, 0, 1, 1);
    chk("clear_idle_ovf", {31'd0, ovf}, 1);

    // 4. SUB underflow, then clear
    step(1, 1, 5, 9, 0, 1);     chk("sub_under", 32'(result), SAT ? 0 : 1020);
    step(1, 2, 1, 0, 1, 1);     chk("clr_acc_1", 32'(result), 1);
    chk("clr_ovf", {31'd0, ovf}, 0);
    chk("clr_cnt", 32'(op_count), 1);
    step(1, 3, 5, 77, 0, 1);    chk("dacc_under", 32'(result), SAT ? 0 : 1020);

    // 5. backpressure
    step(1, 0, 3, 4, 0, 1);     chk("bp_7", 32'(result), 7);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 10, 10, 0, 0);
      chk("bp_hold", 32'(result), 7);
    end
    step(1, 0, 10, 10, 0, 1);   chk("bp_20", 32'(result), 20);
    for (int i = 0; i < 6; i++) begin
      step(1, 2, i * 7, i, (i == 0), 1);
      chk("stream_valid", {31'd0, out_valid}, 1);
    end
    step(0, 0, 0, 0, 0, 1);

    // 6. reset during a stall drops the pending result and the accumulator
    step(1, 2, 50, 0, 1, 1);
    step(1, 0, 3, 4, 0, 1);
    step(1, 0, 10, 10, 0, 0);
    in_valid = 1;
    do_reset(1);
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_ovf", {31'd0, ovf}, 0);
    chk("midrst_cnt", 32'(op_count), 0);
    step(1, 2, 0, 0, 0, 1);     chk("midrst_acc0", 32'(result), 0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
    end
    step(0, 0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
